// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types and helpers for the hazard/forwarding unit
package hazard_pkg;
   typedef logic [4:0] regbits_t;
   typedef enum logic [1:0] {RUN, HAZ, MEMW} hz_state_t;
   localparam regbits_t HZ_REG0 = 5'd0;
   function automatic int fsel_w(input int nstage);
      return $clog2(nstage + 1);
   endfunction
endpackage

// File: rtl/hazard_match.sv
// hazard_match: compares one decode operand against every writer stage and reports the youngest match
module hazard_match
   import hazard_pkg::*;
#(
   parameter int NSTAGE = 3,
   parameter int FSEL_W = 2
)(
   input  logic                  use_r,
   input  regbits_t              r,
   input  logic [NSTAGE-1:0]     stg_wen,
   input  logic [NSTAGE*5-1:0]   stg_dest,
   input  logic                  load0,
   output logic                  hit,
   output logic                  hit_load0,
   output logic [FSEL_W-1:0]     idx
);
   logic [NSTAGE-1:0] m;
   for (genvar g = 0; g < NSTAGE; g++) begin : g_cmp
      assign m[g] = use_r && (r != HZ_REG0) && stg_wen[g] && (stg_dest[g*5 +: 5] == r);
   end
   // scan oldest to youngest so the youngest matching stage overrides
   always_comb begin
      hit = |m;
      hit_load0 = m[0] && load0;
      idx = '0;
      for (int i = NSTAGE - 1; i >= 0; i--)
         if (m[i]) idx = FSEL_W'(i + 1);
   end
endmodule

// File: rtl/hazard_fwd_unit.sv
// hazard_fwd_unit: stall/flush/forwarding control with stall statistics; HAZARD_FWD_EN enables forwarding
module hazard_fwd_unit
   import hazard_pkg::*;
#(
   parameter int NSTAGE = 3,
   parameter int MAX_STALL = 64,
   parameter int CNT_W = 32,
   localparam int FSEL_W = fsel_w(NSTAGE)
)(
   input  logic                  CLK,
   input  logic                  nRST,
   input  logic                  ihit,
   input  logic                  dmem_req,
   input  logic                  dhit,
   input  logic                  branch_taken,
   input  regbits_t              dec_rs,
   input  regbits_t              dec_rt,
   input  logic                  dec_use_rs,
   input  logic                  dec_use_rt,
   input  logic [NSTAGE-1:0]     stg_wen,
   input  logic [NSTAGE*5-1:0]   stg_dest,
   input  logic [NSTAGE-1:0]     stg_load,
   output logic                  pc_stall,
   output logic                  fd_stall,
   output logic                  fd_flush,
   output logic                  dx_flush,
   output logic                  pipe_freeze,
   output logic [FSEL_W-1:0]     fwd_sel_a,
   output logic [FSEL_W-1:0]     fwd_sel_b,
   output logic [CNT_W-1:0]      stall_cnt,
   output logic                  hz_err
);
`ifdef HAZARD_FWD_EN
   localparam bit FWD_EN = 1'b1;
`else
   localparam bit FWD_EN = 1'b0;
`endif
   localparam int RUN_W = $clog2(MAX_STALL + 1);

   logic hit_a, hit_b, l0_a, l0_b, memwait, hazard, stall_haz;
   logic [FSEL_W-1:0] sel_a, sel_b;
   logic [RUN_W-1:0] run_len, run_nxt;
   hz_state_t state, nxt;

   hazard_match #(.NSTAGE(NSTAGE), .FSEL_W(FSEL_W)) u_rs (
      .use_r(dec_use_rs), .r(dec_rs), .stg_wen(stg_wen), .stg_dest(stg_dest),
      .load0(stg_load[0]), .hit(hit_a), .hit_load0(l0_a), .idx(sel_a)
   );
   hazard_match #(.NSTAGE(NSTAGE), .FSEL_W(FSEL_W)) u_rt (
      .use_r(dec_use_rt), .r(dec_rt), .stg_wen(stg_wen), .stg_dest(stg_dest),
      .load0(stg_load[0]), .hit(hit_b), .hit_load0(l0_b), .idx(sel_b)
   );

   // priority-resolved Mealy controls; everything forced low while in reset
   always_comb begin
      memwait = dmem_req && !dhit;
      hazard = FWD_EN ? (l0_a || l0_b) : (hit_a || hit_b);
      stall_haz = hazard && !branch_taken;
      pipe_freeze = nRST && memwait;
      pc_stall = nRST && (memwait || (!branch_taken && (hazard || !ihit)));
      fd_stall = nRST && (memwait || stall_haz);
      fd_flush = nRST && !memwait && (branch_taken || (!hazard && !ihit));
      dx_flush = nRST && !memwait && (branch_taken || hazard);
      fwd_sel_a = (nRST && FWD_EN) ? sel_a : '0;
      fwd_sel_b = (nRST && FWD_EN) ? sel_b : '0;
      nxt = memwait ? MEMW : stall_haz ? HAZ : RUN;
      run_nxt = (nxt == RUN) ? '0 :
                (state == RUN) ? RUN_W'(1) :
                (run_len == RUN_W'(MAX_STALL)) ? run_len : run_len + 1'b1;
   end

   // state, consecutive-stall length, saturating stall total and sticky watchdog
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state <= RUN;
         run_len <= '0;
         stall_cnt <= '0;
         hz_err <= 1'b0;
      end else begin
         state <= nxt;
         run_len <= run_nxt;
         stall_cnt <= stall_cnt + CNT_W'(pc_stall && !(&stall_cnt));
         hz_err <= hz_err || (run_nxt == RUN_W'(MAX_STALL));
      end
   end
endmodule

// File: tb/tb_hazard_fwd_unit.sv
// tb_hazard_fwd_unit: directed and random checks of hazard_fwd_unit against a behavioural model
module tb_hazard_fwd_unit;
   localparam int NSTAGE = 3;
   localparam int MAX_STALL = 64;
   localparam int CNT_W = 32;
   localparam int FSEL_W = $clog2(NSTAGE + 1);
`ifdef HAZARD_FWD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   logic CLK = 1'b0, nRST = 1'b0;
   logic ihit, dmem_req, dhit, branch_taken, dec_use_rs, dec_use_rt;
   logic [4:0] dec_rs, dec_rt;
   logic [NSTAGE-1:0] stg_wen, stg_load;
   logic [NSTAGE*5-1:0] stg_dest;
   logic pc_stall, fd_stall, fd_flush, dx_flush, pipe_freeze, hz_err;
   logic [FSEL_W-1:0] fwd_sel_a, fwd_sel_b;
   logic [CNT_W-1:0] stall_cnt;

   int n_eval = 0, n_fail = 0;
   longint m_cnt = 0;
   int m_run = 0;
   bit m_err = 1'b0;

   always #5 CLK = ~CLK;

   hazard_fwd_unit #(.NSTAGE(NSTAGE), .MAX_STALL(MAX_STALL), .CNT_W(CNT_W)) dut (
      .CLK(CLK), .nRST(nRST), .ihit(ihit), .dmem_req(dmem_req), .dhit(dhit),
      .branch_taken(branch_taken), .dec_rs(dec_rs), .dec_rt(dec_rt),
      .dec_use_rs(dec_use_rs), .dec_use_rt(dec_use_rt), .stg_wen(stg_wen),
      .stg_dest(stg_dest), .stg_load(stg_load), .pc_stall(pc_stall),
      .fd_stall(fd_stall), .fd_flush(fd_flush), .dx_flush(dx_flush),
      .pipe_freeze(pipe_freeze), .fwd_sel_a(fwd_sel_a), .fwd_sel_b(fwd_sel_b),
      .stall_cnt(stall_cnt), .hz_err(hz_err)
   );

   function automatic int youngest(input bit use_r, input logic [4:0] r);
      for (int i = 0; i < NSTAGE; i++)
         if (use_r && r != 0 && stg_wen[i] && stg_dest[i*5 +: 5] == r) return i + 1;
      return 0;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_eval++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic set_stg(input int i, input bit wen, input int dest, input bit ld);
      stg_wen[i] = wen;
      stg_dest[i*5 +: 5] = 5'(dest);
      stg_load[i] = ld;
   endtask

   task automatic clear_in();
      ihit = 1; dmem_req = 0; dhit = 1; branch_taken = 0;
      dec_rs = 0; dec_rt = 0; dec_use_rs = 0; dec_use_rt = 0;
      stg_wen = 0; stg_dest = 0; stg_load = 0;
   endtask

   task automatic cycle(input string tag);
      int ya, yb;
      bit mw, haz, e_pc, e_fds, e_fdf, e_dxf, e_frz;
      @(negedge CLK);
      ya = youngest(dec_use_rs, dec_rs);
      yb = youngest(dec_use_rt, dec_rt);
      mw = dmem_req && !dhit;
      haz = FWD ? ((ya == 1 || yb == 1) && stg_load[0]) : (ya != 0 || yb != 0);
      {e_pc, e_fds, e_fdf, e_dxf, e_frz} = '0;
      if (mw) begin e_pc = 1; e_fds = 1; e_frz = 1; end
      else if (branch_taken) begin e_fdf = 1; e_dxf = 1; end
      else if (haz) begin e_pc = 1; e_fds = 1; e_dxf = 1; end
      else if (!ihit) begin e_pc = 1; e_fdf = 1; end
      chk({tag, ".pc_stall"}, 64'(pc_stall), 64'(e_pc));
      chk({tag, ".fd_stall"}, 64'(fd_stall), 64'(e_fds));
      chk({tag, ".fd_flush"}, 64'(fd_flush), 64'(e_fdf));
      chk({tag, ".dx_flush"}, 64'(dx_flush), 64'(e_dxf));
      chk({tag, ".pipe_freeze"}, 64'(pipe_freeze), 64'(e_frz));
      chk({tag, ".fwd_sel_a"}, 64'(fwd_sel_a), FWD ? 64'(ya) : 64'd0);
      chk({tag, ".fwd_sel_b"}, 64'(fwd_sel_b), FWD ? 64'(yb) : 64'd0);
      chk({tag, ".stall_cnt"}, 64'(stall_cnt), 64'(m_cnt));
      chk({tag, ".hz_err"}, 64'(hz_err), 64'(m_err));
      if (e_pc && m_cnt < 64'hFFFF_FFFF) m_cnt++;
      m_run = (mw || (haz && !branch_taken)) ? m_run + 1 : 0;
      if (m_run >= MAX_STALL) m_err = 1;
      @(posedge CLK);
      #1;
   endtask

   task automatic do_reset(input string tag);
      #2 nRST = 0;
      #1;
      chk({tag, ".pc_stall"}, 64'(pc_stall), 0);
      chk({tag, ".fd_stall"}, 64'(fd_stall), 0);
      chk({tag, ".fd_flush"}, 64'(fd_flush), 0);
      chk({tag, ".dx_flush"}, 64'(dx_flush), 0);
      chk({tag, ".pipe_freeze"}, 64'(pipe_freeze), 0);
      chk({tag, ".fwd_sel_a"}, 64'(fwd_sel_a), 0);
      chk({tag, ".fwd_sel_b"}, 64'(fwd_sel_b), 0);
      chk({tag, ".stall_cnt"}, 64'(stall_cnt), 0);
      chk({tag, ".hz_err"}, 64'(hz_err), 0);
      m_cnt = 0; m_run = 0; m_err = 0;
      @(posedge CLK);
      #2 nRST = 1;
   endtask

   initial begin
      clear_in();
      dmem_req = 1; dhit = 0; dec_use_rs = 1; dec_rs = 7; set_stg(0, 1, 7, 1);
      do_reset("reset_init");
      clear_in();
      // forwarding from a non-load in EX; without forwarding it stalls until stg2 drains
      dec_use_rs = 1; dec_rs = 5; set_stg(0, 1, 5, 0);
      cycle("t1_stg0");
      set_stg(0, 0, 0, 0); set_stg(1, 1, 5, 0);
      cycle("t1_stg1");
      set_stg(1, 0, 0, 0); set_stg(2, 1, 5, 0);
      cycle("t1_stg2");
      clear_in();
      cycle("t1_clear");
      // load-use bubble, then load moves to stg1
      dec_use_rt = 1; dec_rt = 5; set_stg(0, 1, 5, 1); set_stg(1, 1, 5, 0);
      cycle("t2_loaduse");
      set_stg(0, 0, 0, 0); set_stg(1, 1, 5, 1); set_stg(2, 1, 5, 0);
      cycle("t2_fwd");
      clear_in();
      // r0 never matches
      dec_use_rs = 1; dec_rs = 0; set_stg(0, 1, 0, 1);
      cycle("t3_r0");
      // memory wait during a data hazard
      clear_in();
      dec_use_rs = 1; dec_rs = 9; set_stg(0, 1, 9, 1); dmem_req = 1; dhit = 0;
      for (int i = 0; i < 3; i++) cycle("t4_memw");
      dhit = 1;
      cycle("t4_done");
      // branch overrides a load-use hazard
      branch_taken = 1;
      cycle("t5_branch");
      clear_in();
      ihit = 0;
      cycle("t_ihit");
      clear_in();
      // reset asserted in the middle of a memory wait
      dmem_req = 1; dhit = 0;
      cycle("t_midstall");
      do_reset("reset_mid");
      // random traffic
      for (int n = 0; n < 400; n++) begin
         ihit = ($urandom_range(0, 3) != 0);
         dmem_req = ($urandom_range(0, 3) == 0);
         dhit = $urandom_range(0, 1) != 0;
         branch_taken = ($urandom_range(0, 5) == 0);
         dec_use_rs = $urandom_range(0, 1) != 0;
         dec_use_rt = $urandom_range(0, 1) != 0;
         dec_rs = 5'($urandom_range(0, 3));
         dec_rt = 5'($urandom_range(0, 3));
         for (int i = 0; i < NSTAGE; i++)
            set_stg(i, $urandom_range(0, 1) != 0, $urandom_range(0, 3), $urandom_range(0, 1) != 0);
         cycle("rand");
      end
      // watchdog: 64 consecutive memory-wait cycles
      clear_in();
      do_reset("reset_pre_wd");
      dmem_req = 1; dhit = 0;
      for (int i = 0; i < MAX_STALL; i++) cycle("t6_wait");
      dhit = 1;
      cycle("t6_after");
      cycle("t6_idle");
      chk("t6_sticky", 64'(hz_err), 64'd1);
      chk("t6_count", 64'(stall_cnt), 64'(MAX_STALL));
      do_reset("reset_final");
      $display("End of test - %0d assertions evaluated, %0d failures", n_eval, n_fail);
      $finish;
   end
endmodule
